// File: rtl/regwrite_arbiter_if.sv
// Write-port bundle between the datapath/deferred requesters and the register-file arbiter.
interface regwrite_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              alu_we;
    logic [4:0]        alu_waddr;
    logic [DATA_W-1:0] alu_wdata;
    logic              def_valid;
    logic [4:0]        def_waddr;
    logic [DATA_W-1:0] def_wdata;
    logic              def_ready;
    logic [4:0]        q_addr;
    logic              q_pending;
    logic              stall_req;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output alu_we, alu_waddr, alu_wdata,
        output def_valid, def_waddr, def_wdata,
        output q_addr,
        input  def_ready, q_pending, stall_req,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  alu_we, alu_waddr, alu_wdata,
        input  def_valid, def_waddr, def_wdata,
        input  q_addr,
        output def_ready, q_pending, stall_req,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: datapath writes win, deferred writes queue in a
// small FIFO and drain into idle cycles, with WAW invalidation and starvation stall.
module regwrite_arbiter #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    regwrite_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

    logic [4:0]        r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_stall;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_alu_eff;
    logic              w_xfer;
    logic              w_def_eff;
    logic              w_empty;
    logic              w_head_vld;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic              w_pending;
    logic [WAIT_W-1:0] w_wait_nxt;

    assign bus.def_ready = !reset && (r_count < FULL_C);

    assign w_alu_eff  = bus.alu_we && (bus.alu_waddr != 5'd0);
    assign w_xfer     = bus.def_valid && bus.def_ready;
    // A same-cycle datapath write to the same register is newer, so the deferred one dies here.
    assign w_def_eff  = w_xfer && (bus.def_waddr != 5'd0) &&
                        !(w_alu_eff && (bus.def_waddr == bus.alu_waddr));
    assign w_empty    = (r_count == '0);
    assign w_head_vld = !w_empty && r_vld[r_rd_ptr];
    assign w_pop      = !w_alu_eff && !w_empty;
    assign w_bypass   = !w_alu_eff && w_empty && w_def_eff;
    assign w_push     = w_def_eff && !w_bypass;

    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == bus.q_addr)) w_pending = 1'b1;
        end
    end

    assign bus.q_pending = !reset && (bus.q_addr != 5'd0) && w_pending;

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_pop || w_empty) begin
            w_wait_nxt = '0;
        end else if (w_head_vld && w_alu_eff && (r_wait != LIMIT_C)) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= '0;
            r_vld      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_wait     <= '0;
            r_stall    <= 1'b0;
        end else begin
            if (w_alu_eff) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= bus.alu_waddr;
                r_rf_wdata <= bus.alu_wdata;
            end else if (w_head_vld) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= r_addr[r_rd_ptr];
                r_rf_wdata <= r_data[r_rd_ptr];
            end else if (w_bypass) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= bus.def_waddr;
                r_rf_wdata <= bus.def_wdata;
            end else begin
                r_rf_we    <= 1'b0;
            end

            if (w_alu_eff) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_addr[i] == bus.alu_waddr) r_vld[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end

            r_wait <= w_wait_nxt;
            if (w_pop) begin
                r_stall <= 1'b0;
            end else if (w_wait_nxt == LIMIT_C) begin
                r_stall <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= bus.def_waddr;
            r_data[r_wr_ptr] <= bus.def_wdata;
        end
    end

    assign bus.stall_req = r_stall;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed scenarios plus random traffic against a queue model.
module tb_regwrite_arbiter;
    localparam int DATA_W       = 32;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regwrite_arbiter_if #(.DATA_W(DATA_W)) bus ();

    regwrite_arbiter #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [4:0]        a;
        logic [DATA_W-1:0] d;
        bit                v;
    } ent_t;

    ent_t              mq[$];
    logic              m_we;
    logic [4:0]        m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_stall;
    int                m_wait;
    int                tests = 0;
    int                fails = 0;
    bit                last_xfer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = '0; m_stall = 1'b0; m_wait = 0;
    endtask

    // Checks all outputs mid-cycle against the model, then advances the model by one clock.
    task automatic cycle();
        bit   rdy, pend, alu_eff, def_eff, head_v, popped, bypass;
        ent_t e;
        @(negedge clk);
        rdy  = !reset && (mq.size() < DEPTH);
        pend = 1'b0;
        if (!reset && bus.q_addr != 5'd0)
            foreach (mq[i]) if (mq[i].v && mq[i].a == bus.q_addr) pend = 1'b1;
        chk("def_ready", 32'(bus.def_ready), 32'(rdy));
        chk("q_pending", 32'(bus.q_pending), 32'(pend));
        chk("rf_we", 32'(bus.rf_we), 32'(m_we));
        chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
        chk("rf_wdata", 32'(bus.rf_wdata), 32'(m_wdata));
        chk("stall_req", 32'(bus.stall_req), 32'(m_stall));
        last_xfer = bus.def_valid && rdy;
        if (reset) begin
            model_reset();
        end else begin
            alu_eff = bus.alu_we && bus.alu_waddr != 5'd0;
            def_eff = last_xfer && bus.def_waddr != 5'd0 &&
                      !(alu_eff && bus.def_waddr == bus.alu_waddr);
            head_v  = (mq.size() > 0) && mq[0].v;
            popped  = 1'b0;
            bypass  = 1'b0;
            if (alu_eff) begin
                foreach (mq[i]) if (mq[i].a == bus.alu_waddr) mq[i].v = 1'b0;
                m_we = 1'b1; m_waddr = bus.alu_waddr; m_wdata = bus.alu_wdata;
                if (head_v && m_wait < STARVE_LIMIT) m_wait++;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                popped = 1'b1;
                m_we = e.v;
                if (e.v) begin m_waddr = e.a; m_wdata = e.d; end
            end else if (def_eff) begin
                bypass = 1'b1;
                m_we = 1'b1; m_waddr = bus.def_waddr; m_wdata = bus.def_wdata;
            end else begin
                m_we = 1'b0;
            end
            if (def_eff && !bypass) begin
                e.a = bus.def_waddr; e.d = bus.def_wdata; e.v = 1'b1;
                mq.push_back(e);
            end
            if (popped || mq.size() == 0) m_wait = 0;
            if (popped) m_stall = 1'b0;
            else if (m_wait == STARVE_LIMIT) m_stall = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.alu_we = 1'b0; bus.alu_waddr = 5'd0; bus.alu_wdata = '0;
        bus.def_valid = 1'b0; bus.def_waddr = 5'd0; bus.def_wdata = '0;
        bus.q_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        chk("rst_def_ready", 32'(bus.def_ready), 0);
        chk("rst_rf_we", 32'(bus.rf_we), 0);

        // Plain datapath write
        reset = 1'b0;
        bus.alu_we = 1'b1; bus.alu_waddr = 5'd8; bus.alu_wdata = 32'h1234;
        cycle();
        chk("t1_we", 32'(bus.rf_we), 1);
        chk("t1_waddr", 32'(bus.rf_waddr), 8);
        chk("t1_wdata", bus.rf_wdata, 32'h1234);

        // Bypass of a deferred write into an idle port
        bus.alu_we = 1'b0;
        bus.def_valid = 1'b1; bus.def_waddr = 5'd9; bus.def_wdata = 32'hA5; bus.q_addr = 5'd9;
        #1;
        chk("t2_ready", 32'(bus.def_ready), 1);
        cycle();
        bus.def_valid = 1'b0;
        chk("t2_we", 32'(bus.rf_we), 1);
        chk("t2_waddr", 32'(bus.rf_waddr), 9);
        chk("t2_pend", 32'(bus.q_pending), 0);

        // Fill the FIFO behind a busy datapath, then drain in order
        bus.alu_we = 1'b1; bus.alu_waddr = 5'd20; bus.alu_wdata = 32'hBEEF;
        for (int k = 1; k <= 4; k++) begin
            bus.def_valid = 1'b1; bus.def_waddr = 5'(k); bus.def_wdata = 32'h100 + k;
            cycle();
        end
        bus.def_waddr = 5'd6; bus.q_addr = 5'd3;
        #1;
        chk("t3_full", 32'(bus.def_ready), 0);
        chk("t3_pend", 32'(bus.q_pending), 1);
        bus.def_valid = 1'b0; bus.alu_we = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("t3_order_we", 32'(bus.rf_we), 1);
            chk("t3_order_addr", 32'(bus.rf_waddr), k);
            chk("t3_order_data", bus.rf_wdata, 32'h100 + k);
        end

        // WAW invalidation by a newer datapath write
        bus.alu_we = 1'b1; bus.alu_waddr = 5'd10; bus.alu_wdata = 32'h1;
        bus.def_valid = 1'b1; bus.def_waddr = 5'd5; bus.def_wdata = 32'h55; bus.q_addr = 5'd5;
        cycle();
        bus.def_valid = 1'b0;
        chk("t4_pend_before", 32'(bus.q_pending), 1);
        bus.alu_waddr = 5'd5; bus.alu_wdata = 32'h77;
        cycle();
        chk("t4_pend_after", 32'(bus.q_pending), 0);
        chk("t4_waddr", 32'(bus.rf_waddr), 5);
        chk("t4_wdata", bus.rf_wdata, 32'h77);
        bus.alu_we = 1'b0;
        cycle();
        chk("t4_dead_pop_we", 32'(bus.rf_we), 0);
        chk("t4_hold_data", bus.rf_wdata, 32'h77);

        // Writes to $0 are swallowed
        bus.def_valid = 1'b1; bus.def_waddr = 5'd0; bus.def_wdata = 32'hDEAD;
        #1;
        chk("t5_ready", 32'(bus.def_ready), 1);
        cycle();
        bus.def_valid = 1'b0;
        chk("t5_def0_we", 32'(bus.rf_we), 0);
        bus.alu_we = 1'b1; bus.alu_waddr = 5'd0; bus.alu_wdata = 32'hFFFF;
        cycle();
        chk("t5_alu0_we", 32'(bus.rf_we), 0);

        // Starvation stall
        bus.alu_waddr = 5'd11; bus.alu_wdata = 32'h11;
        bus.def_valid = 1'b1; bus.def_waddr = 5'd7; bus.def_wdata = 32'h700;
        cycle();
        bus.def_valid = 1'b0;
        repeat (7) cycle();
        chk("t6_no_stall_yet", 32'(bus.stall_req), 0);
        cycle();
        chk("t6_stall", 32'(bus.stall_req), 1);
        bus.alu_we = 1'b0;
        cycle();
        chk("t6_drain_addr", 32'(bus.rf_waddr), 7);
        chk("t6_drain_data", bus.rf_wdata, 32'h700);
        chk("t6_stall_clear", 32'(bus.stall_req), 0);

        // Reset with queued entries discards them
        bus.alu_we = 1'b1; bus.alu_waddr = 5'd12; bus.alu_wdata = 32'h12;
        for (int k = 0; k < 3; k++) begin
            bus.def_valid = 1'b1; bus.def_waddr = 5'(13 + k); bus.def_wdata = 32'h1300 + k;
            cycle();
        end
        bus.def_valid = 1'b0; bus.alu_we = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.q_addr = 5'd13;
        #1;
        chk("t7_pend", 32'(bus.q_pending), 0);
        repeat (3) begin
            cycle();
            chk("t7_no_we", 32'(bus.rf_we), 0);
        end

        // Random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.alu_we = m_stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
            bus.alu_waddr = 5'($urandom_range(0, 7));
            bus.alu_wdata = $urandom;
            if (!bus.def_valid && $urandom_range(0, 1) == 1) begin
                bus.def_valid = 1'b1;
                bus.def_waddr = 5'($urandom_range(0, 7));
                bus.def_wdata = $urandom;
            end
            bus.q_addr = 5'($urandom_range(0, 7));
            cycle();
            if (last_xfer) bus.def_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Shares the single register-file write port between two requesters. The first is the single-cycle datapath writeback: register number already chosen by the RegDst mux, ALU or memory result. The second is a deferred writeback source, a multi-cycle unit such as mult/div or a slow load return.
- Datapath writes always win. Deferred writes are buffered in a small FIFO and drained into idle write-port cycles.
- Provides a pending-register query for hazard stalls, and a starvation stall request so the deferred queue always drains.

Parameters:
- DATA_W, 32, register data width
- DEPTH, 4, deferred-write FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive blocked cycles of a valid FIFO head before stall_req asserts

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- alu_we  input  1  datapath write enable (RegWrite)
- alu_waddr  input  5  datapath destination register (WriteReg)
- alu_wdata  input  DATA_W  datapath write data
- def_valid  input  1  deferred requester has a write
- def_waddr  input  5  deferred destination register
- def_wdata  input  DATA_W  deferred write data
- def_ready  output  1  arbiter accepts deferred write this cycle
- q_addr  input  5  hazard query register number
- q_pending  output  1  q_addr has an outstanding deferred write
- stall_req  output  1  request to freeze datapath so FIFO drains
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  5  register-file write address (registered)
- rf_wdata  output  DATA_W  register-file write data (registered)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset takes effect on the clk edge only.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, FIFO empty with all valid bits cleared, wait counter=0.
- Outputs during reset: def_ready=0 and q_pending=0 while reset is high.
- Effective writes: a write is effective only if its address != 0.
  - alu_we with alu_waddr=0 is treated as no datapath write.
  - A deferred write to $0 is accepted (handshake completes) and discarded.
- Handshake: def_ready = !reset && (count < DEPTH), combinational. A transfer occurs when def_valid && def_ready. def_valid may be held across cycles; the data must remain stable until transferred.
- Port selection each cycle, in priority order (rf_* registered, visible the cycle after selection; latency 1):
  1. Effective datapath write → rf_we=1 with alu_waddr/alu_wdata.
  2. Else, FIFO head valid → rf_we=1 with head addr/data, then pop.
  3. Else, FIFO head invalidated → pop with rf_we=0 (one cycle consumed).
  4. Else, FIFO empty and effective deferred transfer this cycle → bypass: write directly, nothing enqueued.
  5. Else → rf_we=0; rf_waddr/rf_wdata hold their previous values.
- Enqueue: a transferred, effective deferred write not bypassed is pushed at the tail.
  - Push and pop may occur in the same cycle; count is unchanged.
  - A write arriving when the FIFO holds only an invalidated head is enqueued, not bypassed.
- Write-after-write rule (the datapath write is always the newer one):
  - An effective datapath write to X clears the valid bit of every FIFO entry with addr X.
  - A deferred write to X transferred in the same cycle is discarded and not enqueued.
  - Invalidated entries still occupy slots until popped.
- q_pending: combinational; 1 iff q_addr != 0 and any valid FIFO entry has addr == q_addr. The bypass path never sets it.
- Starvation control:
  - wait_cnt increments each cycle the FIFO head is valid and blocked by a datapath write, saturating at STARVE_LIMIT.
  - wait_cnt clears when the head pops or the FIFO empties.
  - stall_req is registered: set the cycle after wait_cnt reaches STARVE_LIMIT, cleared the cycle after the head pops.
  - While stall_req=1 the datapath guarantees alu_we=0. If alu_we=1 arrives anyway, it still wins; no error.
- Full condition: with count=DEPTH, def_ready=0 until a pop.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Reset mid-operation: all queued deferred writes are lost, and no rf_we pulse follows the reset cycle.

Test Plan:
- Reset, then alu_we=1, alu_waddr=8, alu_wdata=0x1234 → next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234. During reset, def_ready=0.
- Idle datapath, def_valid with addr 9, data 0xA5 → def_ready=1, bypass, next cycle rf_we=1 rf_waddr=9; q_pending never 1.
- Continuous alu_we, 4 deferred writes to regs 1..4 → count=4, def_ready=0; q_addr=3 → q_pending=1. Drop alu_we → rf writes 1,2,3,4 in order on 4 consecutive cycles.
- Deferred write to reg 5 queued, then datapath write reg 5 = 0x77 → entry invalidated, q_addr=5 → q_pending=0; later head pop yields rf_we=0, and reg 5's last write is 0x77.
- Deferred write to $0 accepted (def_ready=1) → no rf_we pulse; alu_we with addr 0 → no rf_we pulse.
- One queued entry, alu_we held high 8 cycles → stall_req=1 on cycle 9; alu_we drops → head written, stall_req=0 the following cycle. Assert reset with 3 entries queued → FIFO empty, no later rf_we.
